io_input_ctrl: RTL and testbench
================================

# io_input_ctrl

Memory-mapped input front-end for the board's slide switches and push-buttons, sitting on the same CPU data-memory I/O bus as the display/LED output peripheral. It synchronises and debounces every raw input, latches sticky key-press and switch-change events, and exposes debounced state and events to the CPU through registered reads. It also raises an interrupt request while any unmasked event is pending.

## Interface
- DEBOUNCE_CYCLES, 50000: stable cycles needed before a new input level is accepted (1 ms at 50 MHz); legal range ≥ 2.
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- io_in_sw  in  10  raw slide switches; asynchronous, bouncing.
- io_in_key  in  4  raw push-buttons, active-low (0 = pressed); asynchronous, bouncing.
- addr  in  5  word address on the I/O bus.
- data_in  in  32  CPU write data.
- write_enable  in  1  CPU write strobe, sampled on the rising edge.
- data_out  out  32  registered read data.
- irq  out  1  high while `(key_evt & key_mask) != 0` or `(sw_evt & sw_mask) != 0`.

## Operation
- Sync: every raw bit passes through a 2-flop synchroniser.
  - Switch sync flops reset to 0.
  - Key sync flops reset to 1 (released).
- Debounce: each bit has its own counter and stable register.
  - Synchronised value == stable: counter clears to 0.
  - Synchronised value != stable: counter increments. When it reaches DEBOUNCE_CYCLES−1, stable takes the new value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- Key state is reported active-high: `key_state = ~key_stable`.
- Events:
  - `key_evt[i]` sets on a key_state 0→1 transition (press only).
  - `sw_evt[i]` sets on either edge of switch i's stable value.
  - Both are sticky until cleared.
- Register map. Unused data_out bits read 0.
  - 5 R: sw_stable[4:0]
  - 6 R: sw_stable[9:5]
  - 7 R: key_state[3:0]
  - 8 R/W1C: key_evt[3:0]
  - 9 R/W1C: sw_evt[9:0]
  - 10 R/W: key_mask[3:0]
  - 11 R/W: sw_mask[9:0]
  - All other addresses read 0.
- Writes to read-only or unmapped addresses are ignored.
- Clearing: a write to 8 or 9 clears exactly the event bits whose data_in bit is 1.
- Set and clear of the same event bit in the same cycle: set wins, and the bit stays 1.
- Reads have no side effects.

## Timing
- data_out is registered: the value for the address presented before edge N appears after edge N (1-cycle latency), every cycle regardless of write_enable.
- Reading an event register in the same cycle as a W1C write to it returns the pre-clear value.
- Input-to-state latency for a clean input step:
  - 2 sync cycles + DEBOUNCE_CYCLES cycles, then stable updates.
  - The event bit sets on the same edge as stable updates.
  - irq rises one cycle after the event bit sets.
- A glitch shorter than DEBOUNCE_CYCLES produces no change and no event.
- A glitch that reverts resets its counter to 0.
- irq is registered and deasserts one cycle after the last pending unmasked event clears or is masked.
- Reset values:
  - data_out = 0, irq = 0.
  - All counters = 0, all event and mask registers = 0.
  - sw_stable = 0, key_stable = all 1s (released).
- Reset asserted mid-debounce or with events pending returns everything to the reset values immediately, with no clock edge required.
- After release, no spurious events are raised for inputs already at their reset level.

## Structure
- The shared package `io_pkg` holds:
  - address constants (IO_SW_LO = 5, IO_SW_HI = 6, IO_KEY = 7, IO_KEY_EVT = 8, IO_SW_EVT = 9, IO_KEY_MASK = 10, IO_SW_MASK = 11);
  - the default DEBOUNCE_CYCLES;
  - widths NUM_SW = 10 and NUM_KEY = 4.
- Sub-module `io_debounce`, instantiated 14 times:
  - parameters DEBOUNCE_CYCLES and RESET_LEVEL;
  - ports clock, resetn, raw, stable, rise, fall;
  - contains the synchroniser, counter and stable flop.
  - rise and fall are single-cycle pulses.
- The top level holds the event, mask, irq and read-mux logic.

## Test plan
Use DEBOUNCE_CYCLES = 4 in the bench.

- Press key 2 and hold → key_state reads 0x4 at addr 7; key_evt reads 0x4 at addr 8 after 6 cycles. Write 0x4 to 8 → reads 0x0.
- Bounce io_in_sw[0] 1-0-1-0 with 2-cycle pulses → sw_stable[0] stays 0 and sw_evt stays 0.
- Set io_in_sw = 10'h3E0 and hold → addr 6 reads 0x1F, addr 5 reads 0x00, sw_evt reads 0x3E0.
- With key_mask = 0x1, press key 1 → irq stays 0. Then press key 0 → irq goes to 1; W1C 0x1 on addr 8 → irq goes to 0 one cycle later.
- A key-0 press event arrives on the same edge as a W1C of 0x1 to addr 8 → key_evt[0] remains 1.
- Assert resetn low while a counter is mid-count with events pending → data_out, irq, and all event and mask registers read 0 immediately. After release, no events are raised.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the switch/push-button input front-end.
// Holds the I/O word-address map, default debounce length and input widths.
package io_pkg;

    typedef logic [4:0] io_addr_t;

    localparam int NUM_SW  = 10;
    localparam int NUM_KEY = 4;

    // 1 ms at 50 MHz
    localparam int IO_DEBOUNCE_CYCLES = 50000;

    localparam io_addr_t IO_SW_LO    = 5'd5;
    localparam io_addr_t IO_SW_HI    = 5'd6;
    localparam io_addr_t IO_KEY      = 5'd7;
    localparam io_addr_t IO_KEY_EVT  = 5'd8;
    localparam io_addr_t IO_SW_EVT   = 5'd9;
    localparam io_addr_t IO_KEY_MASK = 5'd10;
    localparam io_addr_t IO_SW_MASK  = 5'd11;

endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus per-bit debounce counter.
// Ports: clock, resetn, raw (async input), stable (debounced level),
//        rise/fall (one-cycle pulses, high in the cycle whose edge updates stable).
module io_debounce
    import io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;
    logic          settle;

    // settle is the cycle where the counter has run out and stable flips
    // on the coming edge; pulses are aligned with that edge so event bits
    // latch together with the new stable value.
    assign settle = (sync_b != stable) && (cnt == CNT_LAST);
    assign rise   = settle && sync_b;
    assign fall   = settle && !sync_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_a <= RESET_LEVEL;
            sync_b <= RESET_LEVEL;
            stable <= RESET_LEVEL;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped switch/key input block with sticky events and irq.
// Ports: clock, resetn, io_in_sw[9:0], io_in_key[3:0] (active-low), addr, data_in,
//        write_enable, data_out (registered read), irq (registered).
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [9:0]  io_in_sw,
    input  logic [3:0]  io_in_key,
    input  logic [4:0]  addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    output logic [31:0] data_out,
    output logic        irq
);

    logic [NUM_SW-1:0]  sw_stable;
    logic [NUM_SW-1:0]  sw_rise;
    logic [NUM_SW-1:0]  sw_fall;
    logic [NUM_KEY-1:0] key_stable;
    logic [NUM_KEY-1:0] key_rise;
    logic [NUM_KEY-1:0] key_fall;
    logic [NUM_KEY-1:0] key_state;

    logic [NUM_KEY-1:0] key_evt;
    logic [NUM_SW-1:0]  sw_evt;
    logic [NUM_KEY-1:0] key_mask;
    logic [NUM_SW-1:0]  sw_mask;

    logic [NUM_KEY-1:0] key_set;
    logic [NUM_KEY-1:0] key_clr;
    logic [NUM_SW-1:0]  sw_set;
    logic [NUM_SW-1:0]  sw_clr;
    logic [31:0]        rd_data;
    logic               irq_next;
    logic               unused_ok;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        io_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b0)
        ) u_db (
            .clock  (clock),
            .resetn (resetn),
            .raw    (io_in_sw[i]),
            .stable (sw_stable[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
        io_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b1)
        ) u_db (
            .clock  (clock),
            .resetn (resetn),
            .raw    (io_in_key[i]),
            .stable (key_stable[i]),
            .rise   (key_rise[i]),
            .fall   (key_fall[i])
        );
    end

    // Keys are active-low: a falling debounced level is a press.
    assign key_state = ~key_stable;
    assign key_set   = key_fall;
    assign sw_set    = sw_rise | sw_fall;

    assign key_clr = (write_enable && addr == IO_KEY_EVT) ?
                     data_in[NUM_KEY-1:0] : '0;
    assign sw_clr  = (write_enable && addr == IO_SW_EVT) ?
                     data_in[NUM_SW-1:0] : '0;

    assign irq_next = (|(key_evt & key_mask)) | (|(sw_evt & sw_mask));

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            (addr == IO_SW_LO):    rd_data = 32'(sw_stable[4:0]);
            (addr == IO_SW_HI):    rd_data = 32'(sw_stable[9:5]);
            (addr == IO_KEY):      rd_data = 32'(key_state);
            (addr == IO_KEY_EVT):  rd_data = 32'(key_evt);
            (addr == IO_SW_EVT):   rd_data = 32'(sw_evt);
            (addr == IO_KEY_MASK): rd_data = 32'(key_mask);
            (addr == IO_SW_MASK):  rd_data = 32'(sw_mask);
            default:               rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_evt  <= '0;
            sw_evt   <= '0;
            key_mask <= '0;
            sw_mask  <= '0;
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            // OR-ing the set term last makes a same-edge set win over clear.
            key_evt  <= (key_evt & ~key_clr) | key_set;
            sw_evt   <= (sw_evt & ~sw_clr) | sw_set;
            if (write_enable && addr == IO_KEY_MASK)
                key_mask <= data_in[NUM_KEY-1:0];
            if (write_enable && addr == IO_SW_MASK)
                sw_mask <= data_in[NUM_SW-1:0];
            data_out <= rd_data;
            irq      <= irq_next;
        end
    end

    assign unused_ok = &{1'b0, data_in[31:NUM_SW], key_rise};

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed + random bench for io_input_ctrl.
// Reference model decides debounced levels from a sliding window of raw samples.
module tb_io_input_ctrl;

    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic [9:0]  io_in_sw;
    logic [3:0]  io_in_key;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;
    logic        irq;

    always #5 clock = ~clock;

    io_input_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .io_in_sw     (io_in_sw),
        .io_in_key    (io_in_key),
        .addr         (addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out),
        .irq          (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: raw samples per edge, {key, sw}
    logic [13:0] hist[$];
    logic [9:0]  m_sw, m_sw_evt, m_sw_mask;
    logic [3:0]  m_key, m_key_evt, m_key_mask;
    logic [31:0] m_dout;
    logic        m_irq;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd5:    return {27'b0, m_sw[4:0]};
            5'd6:    return {27'b0, m_sw[9:5]};
            5'd7:    return {28'b0, ~m_key};
            5'd8:    return {28'b0, m_key_evt};
            5'd9:    return {22'b0, m_sw_evt};
            5'd10:   return {28'b0, m_key_mask};
            5'd11:   return {22'b0, m_sw_mask};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < DC + 2; k++) hist.push_back({4'hF, 10'h0});
        m_sw = '0; m_sw_evt = '0; m_sw_mask = '0;
        m_key = 4'hF; m_key_evt = '0; m_key_mask = '0;
        m_dout = '0; m_irq = 1'b0;
    endtask

    // A level is accepted once the DC samples taken 2..DC+1 edges ago
    // all agree on a value different from the current stable level.
    task automatic model_edge();
        logic [13:0] cur, nxt, h;
        logic        all0, all1;
        logic [3:0]  kclr;
        logic [9:0]  sclr;
        logic [31:0] dn;
        logic        irqn;
        dn   = m_read(addr);
        irqn = (|(m_key_evt & m_key_mask)) | (|(m_sw_evt & m_sw_mask));
        hist.push_back({io_in_key, io_in_sw});
        while (hist.size() > DC + 2) hist.delete(0);
        cur = {m_key, m_sw};
        nxt = cur;
        for (int b = 0; b < 14; b++) begin
            all0 = 1'b1;
            all1 = 1'b1;
            for (int k = 0; k < DC; k++) begin
                h = hist[k];
                if (h[b]) all0 = 1'b0;
                else all1 = 1'b0;
            end
            if (all1) nxt[b] = 1'b1;
            else if (all0) nxt[b] = 1'b0;
        end
        kclr = (write_enable && addr == 5'd8) ? data_in[3:0] : 4'h0;
        sclr = (write_enable && addr == 5'd9) ? data_in[9:0] : 10'h0;
        m_key_evt = (m_key_evt & ~kclr) | (cur[13:10] & ~nxt[13:10]);
        m_sw_evt  = (m_sw_evt & ~sclr) | (cur[9:0] ^ nxt[9:0]);
        if (write_enable && addr == 5'd10) m_key_mask = data_in[3:0];
        if (write_enable && addr == 5'd11) m_sw_mask = data_in[9:0];
        m_key  = nxt[13:10];
        m_sw   = nxt[9:0];
        m_dout = dn;
        m_irq  = irqn;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("data_out", data_out, m_dout);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr = a;
        data_in = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        data_in = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr = a;
        write_enable = 1'b0;
        step();
        v = data_out;
    endtask

    logic [31:0] v;
    int          b;

    initial begin
        resetn = 1'b1;
        io_in_sw = '0;
        io_in_key = 4'hF;
        addr = '0;
        data_in = '0;
        write_enable = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rst_dout", data_out, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        #9 resetn = 1'b1;
        idle(4);

        // key 2 press
        io_in_key = 4'b1011;
        addr = 5'd8;
        repeat (6) step();
        check("key_evt_early", data_out, 32'h0);
        step();
        check("key_evt", data_out, 32'h4);
        rd(5'd7, v);
        check("key_state", v, 32'h4);
        wr(5'd8, 32'h4);
        check("w1c_pre", data_out, 32'h4);
        rd(5'd8, v);
        check("w1c_post", v, 32'h0);
        io_in_key = 4'hF;
        idle(8);
        rd(5'd8, v);
        check("no_release_evt", v, 32'h0);

        // switch 0 bounce with 2-cycle pulses
        for (int i = 0; i < 8; i++) begin
            io_in_sw[0] = ((i / 2) % 2 == 0);
            step();
        end
        idle(8);
        rd(5'd5, v);
        check("bounce_stable", v, 32'h0);
        rd(5'd9, v);
        check("bounce_evt", v, 32'h0);

        // upper switches
        io_in_sw = 10'h3E0;
        idle(8);
        rd(5'd6, v);
        check("sw_hi", v, 32'h1F);
        rd(5'd5, v);
        check("sw_lo", v, 32'h0);
        rd(5'd9, v);
        check("sw_evt", v, 32'h3E0);
        wr(5'd9, 32'h3FF);
        rd(5'd9, v);
        check("sw_evt_clr", v, 32'h0);

        // masking
        wr(5'd10, 32'h1);
        io_in_key = 4'b1101;
        idle(8);
        check("irq_masked", {31'b0, irq}, 32'h0);
        io_in_key = 4'b1100;
        idle(8);
        check("irq_on", {31'b0, irq}, 32'h1);
        wr(5'd8, 32'h1);
        check("irq_hold", {31'b0, irq}, 32'h1);
        idle(1);
        check("irq_off", {31'b0, irq}, 32'h0);
        io_in_key = 4'hF;
        idle(8);
        wr(5'd8, 32'hF);

        // set beats clear on the same edge
        io_in_key = 4'b1110;
        repeat (5) step();
        addr = 5'd8;
        data_in = 32'h1;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        data_in = '0;
        step();
        check("set_wins", data_out, 32'h1);

        // async reset mid-count with events pending
        wr(5'd10, 32'hF);
        idle(2);
        check("irq_pending", {31'b0, irq}, 32'h1);
        io_in_sw = 10'h3E1;
        repeat (4) step();
        #2 resetn = 1'b0;
        io_in_sw = '0;
        io_in_key = 4'hF;
        #1;
        check("mid_rst_dout", data_out, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        #2 resetn = 1'b1;
        idle(10);
        rd(5'd8, v);
        check("rst_key_evt", v, 32'h0);
        rd(5'd9, v);
        check("rst_sw_evt", v, 32'h0);
        rd(5'd10, v);
        check("rst_key_mask", v, 32'h0);
        rd(5'd11, v);
        check("rst_sw_mask", v, 32'h0);
        rd(5'd7, v);
        check("rst_key_state", v, 32'h0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) begin
                b = int'($urandom_range(13));
                if (b < 10) io_in_sw[b] = ~io_in_sw[b];
                else io_in_key[b-10] = ~io_in_key[b-10];
            end
            addr = 5'($urandom_range(15));
            write_enable = ($urandom_range(3) == 0);
            data_in = $urandom;
            step();
        end
        write_enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
